// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router ingress controller.
// Contents: FSM state encoding, port count and the reserved address code
// that marks a packet for discard.
package router_pkg;

  localparam int         NUM_PORTS    = 3;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [3:0] {
    DECODE,
    WAIT,
    LFD,
    LOAD_DATA,
    FIFO_FULL,
    LAF,
    LOAD_PARITY,
    CHECK_PARITY,
    DROP
  } state_t;

endpackage

// File: rtl/router_sft_timer.sv
// Per-port soft-reset watchdog. Counts consecutive cycles in which the
// FIFO holds data that its destination does not read, and emits a
// single-cycle sft_rst when the count reaches TIMEOUT.
// Ports:
//   clk      clock, posedge
//   rst      synchronous active-low reset
//   vld      FIFO holds data (~fifo_empty)
//   rd_en    destination read enable
//   sft_rst  soft-reset pulse for this FIFO
module router_sft_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd_en,
  output logic sft_rst
);

  logic [CNT_W-1:0] cnt;
  logic             stuck;

  // Data pending and nobody reading: the only condition that advances the count.
  assign stuck   = vld & ~rd_en;
  // The pulse fires on the TIMEOUT-th stuck cycle; a read on that cycle suppresses it.
  assign sft_rst = stuck & (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!stuck || sft_rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/router_ctrl.sv
// Ingress controller for the 1x3 router. Decodes the packet header,
// sequences header/payload/parity writes into one of three FIFOs, stalls
// upstream through busy when the target FIFO is full or still draining,
// and runs a soft-reset watchdog per FIFO. Carries control only.
// Ports:
//   clk, rst          clock (posedge) and synchronous active-low reset
//   pkt_valid         high on header/payload bytes, low on the parity byte
//   addr              destination field of the current byte (3 = invalid)
//   fifo_full/empty   status flags per FIFO
//   rd_en             read enable from each destination
//   we                one-hot (or zero) FIFO write enable
//   lfd_state .. rst_int_reg   state-decoded strobes for the datapath
//   busy              upstream must hold its byte and pkt_valid
//   sft_rst           per-FIFO soft-reset pulse
//   vld_out           per-FIFO data available (~fifo_empty)
module router_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] addr,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] rd_en,
  output logic [2:0] we,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       detect_add,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [2:0] sft_rst,
  output logic [2:0] vld_out
);

  state_t     state;
  logic [1:0] addr_q;

  // Flags padded to four entries so a 2-bit index is always in range.
  logic [3:0] empty_x, full_x, sft_x;
  logic       tgt_full, tgt_empty, tgt_sft;
  logic       abort, wcond;
  logic [3:0] sel;

  assign empty_x   = {1'b0, fifo_empty};
  assign full_x    = {1'b0, fifo_full};
  assign sft_x     = {1'b0, sft_rst};
  assign tgt_full  = full_x[addr_q];
  assign tgt_empty = empty_x[addr_q];
  assign tgt_sft   = sft_x[addr_q];

  // A watchdog flush of the target FIFO kills the packet being written.
  assign abort = tgt_sft & (state inside {LFD, LOAD_DATA, FIFO_FULL, LAF, LOAD_PARITY});

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wd
    router_sft_timer #(
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
    ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .vld    (~fifo_empty[i]),
      .rd_en  (rd_en[i]),
      .sft_rst(sft_rst[i])
    );
  end

  // Write condition and backpressure, decoded from state and live flags.
  always_comb begin
    wcond = 1'b0;
    busy  = 1'b0;
    case (state)
      WAIT:         busy = 1'b1;
      LFD: begin
        busy  = 1'b1;
        wcond = ~tgt_full;
      end
      LOAD_DATA: begin
        busy  = ~pkt_valid | tgt_full;
        wcond = pkt_valid & ~tgt_full;
      end
      FIFO_FULL:    busy = 1'b1;
      LAF: begin
        busy  = 1'b1;
        wcond = 1'b1;
      end
      LOAD_PARITY: begin
        busy  = 1'b1;
        wcond = ~tgt_full;
      end
      CHECK_PARITY: busy = 1'b1;
      default: begin
        wcond = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  assign sel = 4'b0001 << addr_q;
  assign we  = sel[2:0] & {3{wcond & ~abort}};

  assign lfd_state   = (state == LFD);
  assign ld_state    = (state == LOAD_DATA);
  assign full_state  = (state == FIFO_FULL);
  assign laf_state   = (state == LAF);
  assign detect_add  = (state == DECODE);
  assign rst_int_reg = (state == CHECK_PARITY);
  assign vld_out     = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= DECODE;
      addr_q <= '0;
    end else if (abort) begin
      // Remaining bytes of a live packet must still be swallowed.
      state <= pkt_valid ? DROP : DECODE;
    end else begin
      case (state)
        DECODE: begin
          if (pkt_valid) begin
            if (addr == ADDR_INVALID) begin
              state <= DROP;
            end else begin
              addr_q <= addr;
              state  <= empty_x[addr] ? LFD : WAIT;
            end
          end
        end
        WAIT:         if (tgt_empty) state <= LFD;
        LFD:          state <= LOAD_DATA;
        LOAD_DATA: begin
          if (!pkt_valid)    state <= LOAD_PARITY;
          else if (tgt_full) state <= FIFO_FULL;
        end
        FIFO_FULL:    if (!tgt_full) state <= LAF;
        LAF:          state <= pkt_valid ? LOAD_DATA : LOAD_PARITY;
        LOAD_PARITY:  if (!tgt_full) state <= CHECK_PARITY;
        CHECK_PARITY: state <= DECODE;
        DROP:         if (!pkt_valid) state <= DECODE;
        default:      state <= DECODE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Bench for router_ctrl: cycle tables of {inputs, expected outputs} plus
// hand-built sequences for watchdog, abort and mid-packet reset.
module tb_router_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] rd_en = 3'b111;
  logic [2:0] we, sft_rst, vld_out;
  logic       lfd_state, ld_state, full_state, laf_state, detect_add, rst_int_reg, busy;

  router_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .addr       (addr),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .rd_en      (rd_en),
    .we         (we),
    .lfd_state  (lfd_state),
    .ld_state   (ld_state),
    .full_state (full_state),
    .laf_state  (laf_state),
    .detect_add (detect_add),
    .rst_int_reg(rst_int_reg),
    .busy       (busy),
    .sft_rst    (sft_rst),
    .vld_out    (vld_out)
  );

  always #5 clk = ~clk;

  // Flag vector order: {lfd, ld, full, laf, detect_add, rst_int_reg}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_LFD  = 6'b100000;
  localparam logic [5:0] F_LD   = 6'b010000;
  localparam logic [5:0] F_FULL = 6'b001000;
  localparam logic [5:0] F_LAF  = 6'b000100;
  localparam logic [5:0] F_DET  = 6'b000010;
  localparam logic [5:0] F_RINT = 6'b000001;

  typedef struct {
    logic       pv;
    logic [1:0] a;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] rd;
    logic [2:0] we;
    logic       busy;
    logic [5:0] fl;
    logic [2:0] sft;
    string      nm;
  } vec_t;

  typedef struct {
    logic [9:0] ctl;
    logic [5:0] aux;
    string      nm;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t V(input logic pv, input logic [1:0] a, input logic [2:0] full,
                             input logic [2:0] empty, input logic [2:0] rd, input logic [2:0] w,
                             input logic b, input logic [5:0] fl, input logic [2:0] s,
                             input string nm);
    vec_t v;
    v.pv = pv; v.a = a; v.full = full; v.empty = empty; v.rd = rd;
    v.we = w; v.busy = b; v.fl = fl; v.sft = s; v.nm = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic compare_now();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = sb.pop_front();
    check({e.nm, "/ctl"},
          {6'b0, we, busy, lfd_state, ld_state, full_state, laf_state, detect_add, rst_int_reg},
          {6'b0, e.ctl});
    check({e.nm, "/sft_vld"}, {10'b0, sft_rst, vld_out}, {10'b0, e.aux});
  endtask

  // Drive one cycle's inputs after the edge, compare combinational outputs mid-cycle.
  task automatic run_vec(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    pkt_valid  = v.pv;
    addr       = v.a;
    fifo_full  = v.full;
    fifo_empty = v.empty;
    rd_en      = v.rd;
    e.ctl = {v.we, v.busy, v.fl};
    e.aux = {v.sft, ~v.empty};
    e.nm  = v.nm;
    sb.push_back(e);
    @(negedge clk);
    compare_now();
  endtask

  task automatic expect_reset_state(input string nm);
    exp_t e;
    e.ctl = {3'b000, 1'b0, F_DET};
    e.aux = {3'b000, ~fifo_empty};
    e.nm  = nm;
    sb.push_back(e);
    compare_now();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Normal packet to port 1: header + 3 payload + parity = 5 writes.
    tbl.push_back(V(1, 1, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  0, "np_hdr"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b010, 1, F_LFD,  0, "np_lfd"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b010, 0, F_LD,   0, "np_d0"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b010, 0, F_LD,   0, "np_d1"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b010, 0, F_LD,   0, "np_d2"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_LD,   0, "np_pvlow"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b010, 1, F_NONE, 0, "np_par"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_RINT, 0, "np_chk"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  0, "np_idle"));
    // Full stall on port 0 mid-payload, and full during parity.
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  0, "fs_hdr"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b001, 1, F_LFD,  0, "fs_lfd"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b001, 0, F_LD,   0, "fs_d0"));
    tbl.push_back(V(1, 0, 3'b001, 3'b111, 3'b111, 3'b000, 1, F_LD,   0, "fs_full"));
    tbl.push_back(V(1, 0, 3'b001, 3'b111, 3'b111, 3'b000, 1, F_FULL, 0, "fs_hold"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_FULL, 0, "fs_free"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b001, 1, F_LAF,  0, "fs_laf"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_LD,   0, "fs_pvlow"));
    tbl.push_back(V(0, 0, 3'b001, 3'b111, 3'b111, 3'b000, 1, F_NONE, 0, "fs_parfull"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b001, 1, F_NONE, 0, "fs_par"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_RINT, 0, "fs_chk"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  0, "fs_idle"));
    // Full release and pkt_valid drop together: LAF then straight to parity.
    tbl.push_back(V(1, 2, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  0, "se_hdr"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b100, 1, F_LFD,  0, "se_lfd"));
    tbl.push_back(V(1, 0, 3'b100, 3'b111, 3'b111, 3'b000, 1, F_LD,   0, "se_full"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_FULL, 0, "se_both"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b100, 1, F_LAF,  0, "se_laf"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b100, 1, F_NONE, 0, "se_par"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_RINT, 0, "se_chk"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  0, "se_idle"));
    // Busy wait: port 2 still draining.
    tbl.push_back(V(1, 2, 3'b000, 3'b011, 3'b111, 3'b000, 0, F_DET,  0, "bw_hdr"));
    tbl.push_back(V(1, 0, 3'b000, 3'b011, 3'b111, 3'b000, 1, F_NONE, 0, "bw_w0"));
    tbl.push_back(V(1, 0, 3'b000, 3'b011, 3'b111, 3'b000, 1, F_NONE, 0, "bw_w1"));
    tbl.push_back(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_NONE, 0, "bw_w2"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b100, 1, F_LFD,  0, "bw_lfd"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_LD,   0, "bw_pvlow"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b100, 1, F_NONE, 0, "bw_par"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 1, F_RINT, 0, "bw_chk"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  0, "bw_idle"));
    // Invalid address: dropped without writes or backpressure.
    tbl.push_back(V(1, 3, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  0, "ia_hdr"));
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(1, 2'(i), 3'b000, 3'b111, 3'b111, 3'b000, 0, F_NONE, 0, "ia_drop"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_NONE, 0, "ia_par"));
    tbl.push_back(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  0, "ia_idle"));

    // Reset state.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Abort: port 0 watchdog fires while the packet is loading.
    run_vec(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET, 0, "ab_hdr"));
    run_vec(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b001, 1, F_LFD, 0, "ab_lfd"));
    for (int k = 1; k <= 29; k++)
      run_vec(V(1, 0, 3'b000, 3'b110, 3'b110, 3'b001, 0, F_LD, 0, $sformatf("ab_ld%0d", k)));
    run_vec(V(1, 0, 3'b000, 3'b110, 3'b110, 3'b000, 0, F_LD,   3'b001, "ab_fire"));
    run_vec(V(1, 0, 3'b000, 3'b110, 3'b110, 3'b000, 0, F_NONE, 3'b000, "ab_drop"));
    run_vec(V(0, 0, 3'b000, 3'b110, 3'b110, 3'b000, 0, F_NONE, 3'b000, "ab_pvlow"));
    run_vec(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET,  3'b000, "ab_idle"));

    // Watchdog in idle: pulse on the 30th unread cycle only.
    for (int k = 1; k <= 31; k++)
      run_vec(V(0, 0, 3'b000, 3'b110, 3'b110, 3'b000, 0, F_DET,
                (k == 30) ? 3'b001 : 3'b000, $sformatf("wd%0d", k)));
    run_vec(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET, 0, "wd_clr"));

    // Read at cycle 29 restarts the count; read on a firing cycle suppresses it.
    for (int k = 1; k <= 90; k++)
      run_vec(V(0, 0, 3'b000, 3'b110, (k == 29 || k == 89) ? 3'b111 : 3'b110, 3'b000, 0,
                F_DET, (k == 59) ? 3'b001 : 3'b000, $sformatf("wv%0d", k)));
    run_vec(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET, 0, "wv_clr"));

    // Reset in the middle of a packet.
    run_vec(V(1, 1, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET, 0, "rp_hdr"));
    run_vec(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b010, 1, F_LFD, 0, "rp_lfd"));
    run_vec(V(1, 0, 3'b000, 3'b111, 3'b111, 3'b010, 0, F_LD,  0, "rp_ld"));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    expect_reset_state("rp_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    pkt_valid = 1'b0;
    run_vec(V(0, 0, 3'b000, 3'b111, 3'b111, 3'b000, 0, F_DET, 0, "rp_idle"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
- Ingress controller for the 1x3 router.
- Decodes each packet header, sequences FIFO writes (header, payload, parity) into one of three output FIFOs, and handles full stalls with upstream backpressure.
- Runs a per-port soft-reset watchdog that flushes a FIFO whose destination stops reading.
- Sits between the input register stage and the three packet FIFOs; carries no data bytes, only control.

Parameters:
TIMEOUT, 30, consecutive unread cycles with data pending before sft_rst fires
CNT_W, 5, watchdog counter width; 2**CNT_W must be >= TIMEOUT

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-low reset
pkt_valid  in  1  high for header and payload bytes; low on the parity byte
addr  in  2  bits [1:0] of the current input byte; 3 = invalid
fifo_full  in  3  full flag per FIFO
fifo_empty  in  3  empty flag per FIFO
rd_en  in  3  read enable from each destination
we  out  3  write enable per FIFO, one-hot or zero
lfd_state  out  1  header-write cycle; marks the header bit in the FIFO
ld_state  out  1  in LOAD_DATA
full_state  out  1  in FIFO_FULL
laf_state  out  1  in LOAD_AFTER_FULL
detect_add  out  1  in DECODE
rst_int_reg  out  1  one-cycle pulse in CHECK_PARITY; clears the parity accumulator
busy  out  1  upstream must hold current byte and pkt_valid
sft_rst  out  3  per-FIFO soft-reset pulse
vld_out  out  3  ~fifo_empty

Behaviour:
- Reset (rst=0 at posedge):
  - state=DECODE, addr_q=0, counters=0.
  - Outputs are combinational from state, so during reset: we=0, sft_rst=0, busy=0, detect_add=1.
- Upstream advances a byte only on a cycle where busy=0.
- we[i]=(i==addr_q) & wcond; wcond is given per state below.
- FSM states and transitions:
  - DECODE:
    - pkt_valid & addr!=3 & fifo_empty[addr] -> LFD; latch addr_q.
    - pkt_valid & addr!=3 & !fifo_empty[addr] -> WAIT; latch addr_q.
    - pkt_valid & addr==3 -> DROP.
    - Otherwise stay.
    - busy=0, wcond=0.
  - WAIT: busy=1; -> LFD when fifo_empty[addr_q].
  - LFD: busy=1, lfd_state=1, wcond=!fifo_full; -> LOAD_DATA.
  - LOAD_DATA:
    - !pkt_valid -> LOAD_PARITY; byte not written.
    - Else fifo_full[addr_q] -> FIFO_FULL; byte not written.
    - Else write and stay.
    - busy=!pkt_valid | fifo_full[addr_q]; wcond=pkt_valid & !fifo_full[addr_q].
  - FIFO_FULL: busy=1, wcond=0; -> LAF when !fifo_full[addr_q].
  - LAF: busy=1, wcond=1 (writes the held byte); -> LOAD_DATA if pkt_valid, else LOAD_PARITY.
  - LOAD_PARITY: busy=1, wcond=!fifo_full[addr_q]; -> CHECK_PARITY when written, else stay.
  - CHECK_PARITY: busy=1, rst_int_reg=1; -> DECODE.
  - DROP: busy=0, we=0; -> DECODE on the first cycle with pkt_valid=0 (parity consumed that cycle).
- Abort:
  - Applies when sft_rst[addr_q]=1 in LFD, LOAD_DATA, FIFO_FULL, LAF or LOAD_PARITY.
  - Next state = DROP if pkt_valid, else DECODE; we=0 that cycle.
  - Abort has priority over every other transition.
- Watchdog, per port i:
  - cnt_i clears when rd_en[i] | fifo_empty[i] | sft_rst[i]; otherwise increments.
  - sft_rst[i]=1 for exactly one cycle when cnt_i==TIMEOUT-1 and the clear condition is false; the counter clears on the next edge.
  - A count of TIMEOUT unread cycles with data pending therefore fires sft_rst on the TIMEOUT-th cycle.
  - rd_en arriving on the firing cycle suppresses the pulse.
- Soft reset mid-operation:
  - sft_rst on a FIFO in WAIT: the FIFO empties and the FSM proceeds to LFD normally.
  - sft_rst on a non-target FIFO: no FSM effect.
- Simultaneous events: a full deassertion and a pkt_valid drop in the same cycle in FIFO_FULL -> LAF; LAF then goes to LOAD_PARITY.
- Invariant: at most one we bit high.

Decomposition:
- Package router_pkg:
  - state enum: DECODE, WAIT, LFD, LOAD_DATA, FIFO_FULL, LAF, LOAD_PARITY, CHECK_PARITY, DROP.
  - ADDR_INVALID=2'd3, NUM_PORTS=3.
- Sub-module router_sft_timer (TIMEOUT, CNT_W): inputs clk, rst, vld, rd_en; output sft_rst. Instantiated three times.
- FSM and output decode live in router_ctrl.

Test Plan:
- Normal packet:
  - Stimulus: header 0x0D (len 3, port 1) into empty FIFO1, then 3 payload bytes, then parity.
  - Required: we=3'b010 for 5 cycles total; lfd_state on the first; rst_int_reg one cycle; return to DECODE.
- Busy wait:
  - Stimulus: header to port 2 while fifo_empty[2]=0.
  - Required: WAIT with busy=1 and we=0 until empty; then LFD.
- Full stall:
  - Stimulus: fifo_full[0] rises mid-payload.
  - Required: FIFO_FULL with busy=1 and we=0; full drops -> LAF writes the held byte; back to LOAD_DATA.
- Watchdog:
  - Stimulus: FIFO0 non-empty, rd_en[0]=0 for 30 cycles.
  - Required: sft_rst[0] pulses on cycle 30, one cycle only.
  - Variant: rd_en[0] at cycle 29 -> no pulse, counter 0.
- Invalid address:
  - Stimulus: header addr=3, 4 bytes, pkt_valid low.
  - Required: DROP, we=0 throughout, busy=0, DECODE after the parity cycle.
- Abort:
  - Stimulus: sft_rst[addr_q] during LOAD_DATA with pkt_valid=1.
  - Required: DROP, no further writes; DECODE when pkt_valid falls.
  - Separately: reset mid-packet -> DECODE, we=0.
